// File: rtl/pll_supervisor.sv
// PLL reset sequencer and health monitor: pulses the PLL reset, qualifies lock,
// releases the core reset, then watches lock and output frequency while running.
//
// state     | meaning
// RESET_PLL | pll_rst asserted for RST_CYCLES
// WAIT_LOCK | waiting for synchronized lock, bounded by LOCK_TIMEOUT
// STABLE    | lock must hold LOCK_STABLE consecutive cycles
// RUN       | core out of reset, frequency windows measured
module pll_supervisor #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 500000,
  parameter int WINDOW       = 4096,
  parameter int EXP_EDGES    = 123,
  parameter int TOL          = 2
) (
  input  logic        refclk,
  input  logic        rst_n,
  input  logic        pll_locked,
  input  logic        pll_tick,
  output logic        pll_rst,
  output logic        core_reset_n,
  output logic [1:0]  state,
  output logic [3:0]  retries,
  output logic        freq_err,
  output logic [15:0] edge_count
);

  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam int WW = $clog2(WINDOW + 1);
  localparam int EDGE_HI = EXP_EDGES + TOL;
  localparam int EDGE_LO = EXP_EDGES - TOL;

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t        st;
  logic          lock_s1, lock_s2;
  logic          tick_s1, tick_s2, tick_prev;
  logic [RW-1:0] rst_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [SW-1:0] stable_cnt;
  logic [WW-1:0] win_cnt;
  logic [WW-1:0] edge_cnt;

  logic          tick_edge;
  logic          win_end;
  logic          win_bad;
  logic [WW-1:0] edge_total;
  logic [3:0]    retries_inc;

  assign tick_edge   = tick_s2 ^ tick_prev;
  assign win_end     = (win_cnt == WW'(WINDOW - 1));
  // The edge seen in the window's last cycle still belongs to that window.
  assign edge_total  = edge_cnt + WW'(tick_edge);
  assign win_bad     = (int'(edge_total) > EDGE_HI) || (int'(edge_total) < EDGE_LO);
  assign retries_inc = (retries == 4'hF) ? retries : retries + 4'd1;
  assign state       = st;

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      st           <= RESET_PLL;
      pll_rst      <= 1'b1;
      core_reset_n <= 1'b0;
      retries      <= '0;
      freq_err     <= 1'b0;
      edge_count   <= '0;
      lock_s1      <= 1'b0;
      lock_s2      <= 1'b0;
      tick_s1      <= 1'b0;
      tick_s2      <= 1'b0;
      tick_prev    <= 1'b0;
      rst_cnt      <= '0;
      tmo_cnt      <= '0;
      stable_cnt   <= '0;
      win_cnt      <= '0;
      edge_cnt     <= '0;
    end else begin
      lock_s1   <= pll_locked;
      lock_s2   <= lock_s1;
      tick_s1   <= pll_tick;
      tick_s2   <= tick_s1;
      tick_prev <= tick_s2;

      case (st)
        RESET_PLL: begin
          if (rst_cnt == RW'(RST_CYCLES - 1)) begin
            rst_cnt <= '0;
            pll_rst <= 1'b0;
            st      <= WAIT_LOCK;
          end else begin
            rst_cnt <= rst_cnt + RW'(1);
          end
        end

        WAIT_LOCK: begin
          if (lock_s2) begin
            tmo_cnt    <= '0;
            stable_cnt <= '0;
            st         <= STABLE;
          end else if (tmo_cnt == TW'(LOCK_TIMEOUT - 1)) begin
            tmo_cnt <= '0;
            rst_cnt <= '0;
            pll_rst <= 1'b1;
            retries <= retries_inc;
            st      <= RESET_PLL;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        STABLE: begin
          if (!lock_s2) begin
            stable_cnt <= '0;
            tmo_cnt    <= '0;
            st         <= WAIT_LOCK;
          end else if (stable_cnt == SW'(LOCK_STABLE)) begin
            stable_cnt   <= '0;
            win_cnt      <= '0;
            edge_cnt     <= '0;
            core_reset_n <= 1'b1;
            st           <= RUN;
          end else begin
            stable_cnt <= stable_cnt + SW'(1);
          end
        end

        RUN: begin
          if (win_end) begin
            win_cnt    <= '0;
            edge_cnt   <= '0;
            edge_count <= 16'(edge_total);
            if (win_bad) freq_err <= 1'b1;
          end else begin
            win_cnt  <= win_cnt + WW'(1);
            edge_cnt <= edge_total;
          end
          // Lock loss and a bad window in the same cycle collapse into one restart.
          if (!lock_s2 || (win_end && win_bad)) begin
            rst_cnt      <= '0;
            pll_rst      <= 1'b1;
            core_reset_n <= 1'b0;
            retries      <= retries_inc;
            st           <= RESET_PLL;
          end
        end

        default: begin
          pll_rst      <= 1'b1;
          core_reset_n <= 1'b0;
          rst_cnt      <= '0;
          st           <= RESET_PLL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_supervisor.sv
// Directed bench for pll_supervisor: phase table for power-up, then hand
// sequences for windows, lock loss, glitch, timeout, mid-run reset and collisions.
module tb_pll_supervisor;

  logic        refclk;
  logic        rst_n;
  logic        pll_locked;
  logic        pll_tick;
  logic        pll_rst;
  logic        core_reset_n;
  logic [1:0]  state;
  logic [3:0]  retries;
  logic        freq_err;
  logic [15:0] edge_count;

  int checks = 0;
  int failures = 0;
  int tick_period = 33;

  pll_supervisor #(
    .RST_CYCLES  (16),
    .LOCK_STABLE (1024),
    .LOCK_TIMEOUT(200),
    .WINDOW      (4096),
    .EXP_EDGES   (123),
    .TOL         (2)
  ) dut (
    .refclk      (refclk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .pll_tick    (pll_tick),
    .pll_rst     (pll_rst),
    .core_reset_n(core_reset_n),
    .state       (state),
    .retries     (retries),
    .freq_err    (freq_err),
    .edge_count  (edge_count)
  );

  initial begin
    refclk = 1'b0;
    forever #10 refclk = ~refclk;
  end

  initial begin
    pll_tick = 1'b0;
    forever begin
      repeat (tick_period) @(negedge refclk);
      pll_tick = ~pll_tick;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rst_n;
    logic        locked;
    int          cycles;
    logic [1:0]  st;
    logic        prst;
    logic        core;
    logic [3:0]  retr;
    logic        ferr;
    logic [15:0] ecount;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int limit, input string name);
    int n;
    n = 0;
    while (state !== s && n < limit) begin
      @(negedge refclk);
      n++;
    end
    checks++;
    if (state !== s) begin
      failures++;
      $display("FAIL %s: got state %0d expected state %0d within %0d cycles", name, state, s, limit);
    end
  endtask

  initial begin
    int n;
    int exp_r;
    logic seen_wait;

    // rst_n, locked, cycles, state, pll_rst, core_reset_n, retries, freq_err, edge_count
    vecs[0] = '{1'b0, 1'b0, 5,    2'd0, 1'b1, 1'b0, 4'd0, 1'b0, 16'd0};
    vecs[1] = '{1'b1, 1'b0, 15,   2'd0, 1'b1, 1'b0, 4'd0, 1'b0, 16'd0};
    vecs[2] = '{1'b1, 1'b0, 1,    2'd1, 1'b0, 1'b0, 4'd0, 1'b0, 16'd0};
    vecs[3] = '{1'b1, 1'b0, 84,   2'd1, 1'b0, 1'b0, 4'd0, 1'b0, 16'd0};
    vecs[4] = '{1'b1, 1'b1, 1027, 2'd2, 1'b0, 1'b0, 4'd0, 1'b0, 16'd0};
    vecs[5] = '{1'b1, 1'b1, 1,    2'd3, 1'b0, 1'b1, 4'd0, 1'b0, 16'd0};

    rst_n = 1'b0;
    pll_locked = 1'b0;

    for (int i = 0; i < 6; i++) begin
      rst_n = vecs[i].rst_n;
      pll_locked = vecs[i].locked;
      repeat (vecs[i].cycles) @(negedge refclk);
      chk($sformatf("powerup_vec%0d", i),
          32'({state, pll_rst, core_reset_n, retries, freq_err, edge_count}),
          32'({vecs[i].st, vecs[i].prst, vecs[i].core, vecs[i].retr, vecs[i].ferr, vecs[i].ecount}));
    end

    // First window: result lands exactly 4096 cycles after RUN entry.
    repeat (4095) @(negedge refclk);
    chk("win1_before_end", 32'(edge_count), 32'd0);
    @(negedge refclk);
    chk_range("win1_count", int'(edge_count), 124, 125);
    chk("win1_freq_err", 32'(freq_err), 32'd0);
    chk("win1_state", 32'(state), 32'd3);

    // Lock loss in RUN: core reset drops exactly 3 cycles later.
    pll_locked = 1'b0;
    repeat (2) @(negedge refclk);
    chk("loss_core_at2", 32'(core_reset_n), 32'd1);
    @(negedge refclk);
    chk("loss_core_at3", 32'(core_reset_n), 32'd0);
    chk("loss_state", 32'(state), 32'd0);
    chk("loss_pll_rst", 32'(pll_rst), 32'd1);
    chk("loss_retries", 32'(retries), 32'd1);
    chk("loss_freq_err", 32'(freq_err), 32'd0);
    repeat (15) @(negedge refclk);
    chk("loss_pll_rst_16th", 32'(pll_rst), 32'd1);
    @(negedge refclk);
    chk("loss_pll_rst_end", 32'({state, pll_rst}), 32'({2'd1, 1'b0}));

    // Frequency fault: 40-cycle toggle gives 102 or 103 edges per window.
    tick_period = 40;
    pll_locked = 1'b1;
    wait_state(2'd3, 1500, "fault_reach_run");
    n = 0;
    while (state == 2'd3 && n < 5000) begin
      @(negedge refclk);
      n++;
    end
    chk("fault_run_len", 32'(n), 32'd4096);
    chk_range("fault_count", int'(edge_count), 102, 103);
    chk("fault_freq_err", 32'(freq_err), 32'd1);
    chk("fault_outputs", 32'({state, pll_rst, core_reset_n}), 32'({2'd0, 1'b1, 1'b0}));
    chk("fault_retries", 32'(retries), 32'd2);

    // One-cycle lock glitch deep in STABLE restarts the full stable count.
    tick_period = 33;
    wait_state(2'd2, 300, "glitch_reach_stable");
    repeat (500) @(negedge refclk);
    pll_locked = 1'b0;
    @(negedge refclk);
    pll_locked = 1'b1;
    n = 0;
    seen_wait = 1'b0;
    while (!core_reset_n && n < 2000) begin
      @(negedge refclk);
      n++;
      if (state == 2'd1) seen_wait = 1'b1;
    end
    chk("glitch_to_run", 32'(n), 32'd1028);
    chk("glitch_saw_wait", 32'(seen_wait), 32'd1);
    chk("glitch_retries", 32'(retries), 32'd2);
    chk("glitch_freq_err_sticky", 32'(freq_err), 32'd1);

    // Lock held low: re-pulse period is 16 + LOCK_TIMEOUT, retries saturate.
    pll_locked = 1'b0;
    wait_state(2'd0, 10, "tmo_loss");
    chk("tmo_first_retries", 32'(retries), 32'd3);
    exp_r = 3;
    for (int k = 0; k < 14; k++) begin
      n = 0;
      while (state == 2'd0 && n < 50) begin
        @(negedge refclk);
        n++;
      end
      while (state != 2'd0 && n < 1000) begin
        @(negedge refclk);
        n++;
      end
      exp_r = (exp_r == 15) ? 15 : exp_r + 1;
      chk($sformatf("tmo_period%0d", k), 32'(n), 32'd216);
      chk($sformatf("tmo_retries%0d", k), 32'(retries), 32'(exp_r));
    end

    // Reset mid-run: one low cycle returns everything to reset values.
    pll_locked = 1'b1;
    wait_state(2'd3, 1500, "midrst_reach_run");
    rst_n = 1'b0;
    @(negedge refclk);
    chk("midrst_outputs",
        32'({state, pll_rst, core_reset_n, retries, freq_err, edge_count}),
        32'({2'd0, 1'b1, 1'b0, 4'd0, 1'b0, 16'd0}));
    rst_n = 1'b1;

    // Lock loss seen in the same cycle as a bad window end.
    tick_period = 40;
    wait_state(2'd3, 1500, "coll_reach_run");
    repeat (4093) @(negedge refclk);
    pll_locked = 1'b0;
    repeat (3) @(negedge refclk);
    chk("coll_state", 32'(state), 32'd0);
    chk("coll_retries", 32'(retries), 32'd1);
    chk("coll_freq_err", 32'(freq_err), 32'd1);
    chk_range("coll_count", int'(edge_count), 102, 103);
    @(negedge refclk);
    chk("coll_retries_once", 32'(retries), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_supervisor.md
# pll_supervisor

Reset sequencer and health monitor for the system PLL. Runs on the 50 MHz PLL reference clock, pulses the PLL reset, waits for a stable lock, and only then releases the core reset. While the core runs, it watches `locked` and a divided toggle from the PLL output domain. On lock loss or frequency error it re-asserts core reset and restarts the PLL.

## Interface

Parameters:
- `RST_CYCLES`, 16: length of the PLL reset pulse, in refclk cycles.
- `LOCK_STABLE`, 1024: cycles the synchronized lock must stay high before core reset is released.
- `LOCK_TIMEOUT`, 500000: cycles to wait for lock before the PLL reset is re-pulsed.
- `WINDOW`, 4096: length of the frequency measurement window, in refclk cycles.
- `EXP_EDGES`, 123: expected `pll_tick` edges per window (24 MHz / 16 toggle sampled at 50 MHz).
- `TOL`, 2: allowed absolute deviation from `EXP_EDGES`.

Ports:
- `refclk` in 1: 50 MHz reference clock, the only clock.
- `rst_n` in 1: synchronous, active-low reset.
- `pll_locked` in 1: PLL `locked`. Asynchronous.
- `pll_tick` in 1: toggle generated in the PLL output domain. Asynchronous.
- `pll_rst` out 1: active-high reset to the PLL.
- `core_reset_n` out 1: active-low reset to the downstream core.
- `state` out 2: current state encoding.
- `retries` out 4: count of PLL re-resets, saturating.
- `freq_err` out 1: sticky frequency-fault flag.
- `edge_count` out 16: edge count from the last completed window.

## Operation

- `pll_locked` and `pll_tick` each pass through a 2-FF synchronizer. An edge is any change of the synchronized `pll_tick` from its previous registered value.
- The state machine has four states:
  - RESET_PLL (0): `pll_rst`=1. Counts `RST_CYCLES`, then goes to WAIT_LOCK.
  - WAIT_LOCK (1): `pll_rst`=0. On synchronized lock=1, goes to STABLE. If `LOCK_TIMEOUT` cycles pass without lock, goes to RESET_PLL and increments `retries`.
  - STABLE (2): counts consecutive cycles with lock=1. Any lock=0 clears the counter and returns to WAIT_LOCK; the timeout counter restarts and `retries` does not increment. After `LOCK_STABLE` consecutive cycles, goes to RUN.
  - RUN (3): `core_reset_n`=1. The window counter runs.
    - At the end of each window, the edge count is latched into `edge_count` and the edge counter clears.
    - If |count − `EXP_EDGES`| > `TOL`: set `freq_err`, go to RESET_PLL, and increment `retries`.
    - Synchronized lock=0: go to RESET_PLL and increment `retries`.
- `core_reset_n` is 0 in every state except RUN. It drops in the same cycle the state leaves RUN.
- `retries` saturates at 15. `freq_err` clears only on `rst_n`.
- The edge and window counters clear on entry to RUN, so the first window is a full `WINDOW`.
- If lock loss and a bad window end occur in the same cycle, there is one transition to RESET_PLL, one `retries` increment, and `freq_err` is still set.
- If `rst_n` is asserted mid-operation, all state is abandoned on the next edge.

## Timing

- Reset values while `rst_n`=0, all registered:
  - `state`=RESET_PLL, `pll_rst`=1, `core_reset_n`=0.
  - `retries`=0, `freq_err`=0, `edge_count`=0.
  - Synchronizers and all counters cleared.
- After `rst_n` rises, `pll_rst` stays high for exactly `RST_CYCLES` cycles.
- `pll_locked` to the internal lock signal: 2 cycles. The registered state adds 1 cycle.
- `pll_locked` rise to `core_reset_n` rise: 2 + 1 + `LOCK_STABLE` + 1 cycles, assuming lock holds throughout.
- `pll_locked` fall during RUN to `core_reset_n`=0: exactly 3 cycles.
- `edge_count` and `freq_err` update in the cycle after the last cycle of the window.
- The `edge_count` register is 16 bits. Implementations size their internal counters to hold `WINDOW`, `LOCK_TIMEOUT` and `LOCK_STABLE`.

## Test plan

- Power-up: `rst_n` low for 5 cycles, `pll_locked` raised 100 cycles later, `pll_tick` toggling every 33 cycles.
  - `pll_rst` is high for 16 cycles after `rst_n` rises.
  - `core_reset_n` rises 1028 cycles after `pll_locked` rises.
  - `state`=3.
- Lock glitch in STABLE: `pll_locked` low for 1 cycle at stable-count 500.
  - State returns to WAIT_LOCK, then STABLE again.
  - `core_reset_n` rises a full 1024 stable cycles after the glitch.
  - `retries`=0.
- Lock timeout: `pll_locked` held low.
  - `pll_rst` re-pulses every 16 + 500000 cycles.
  - `retries` counts 1, 2, … and saturates at 15 after 15 timeouts.
- Frequency fault: in RUN, `pll_tick` toggles every 40 cycles (~102 edges per window).
  - After the first window, `edge_count`≈102, `freq_err`=1, `core_reset_n`=0, `state`=0, `retries`=1.
- Lock loss in RUN: drop `pll_locked`.
  - `core_reset_n`=0 exactly 3 cycles later.
  - `pll_rst` pulses for 16 cycles.
  - `freq_err` unchanged.
- Reset mid-run: `rst_n` low for 1 cycle while in RUN.
  - On the next edge all outputs take their reset values, including `retries`=0 and `freq_err`=0.
